cmd_streamer: RTL and testbench

- Fetches 32-bit command words from a memory-resident ring buffer and delivers them in order to the compute unit's instruction/command consumer through a small FIFO.
- Configured by the CSR block's command-streamer outputs (enable, ring base, ring size, initial consumer pointer, completion base).
- Producer pointer arrives via a doorbell.
- Writes the consumer pointer back to the completion address whenever the ring drains.

---
 rtl/gpu_cmd_pkg.sv | 26 ++
 rtl/cmd_streamer_fifo.sv | 64 ++++++
 rtl/cmd_streamer.sv | 222 ++++++++++++++++++++++
 tb/tb_cmd_streamer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_cmd_pkg.sv
// Shared types and helpers for the command streamer: FSM state encoding,
// command word size and the ring pointer wrap rule.
package gpu_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    COMP_REQ   = 2'd3
  } cmd_stream_state_t;

  localparam logic [31:0] CMD_WORD_BYTES = 32'd4;

  // Next consumer offset; a 33-bit sum keeps the compare exact near 2^32.
  function automatic logic [31:0] ring_advance(input logic [31:0] ptr,
                                               input logic [31:0] size);
    logic [32:0] nxt;
    nxt = {1'b0, ptr} + {1'b0, CMD_WORD_BYTES};
    if (nxt >= {1'b0, size}) begin
      ring_advance = '0;
    end else begin
      ring_advance = nxt[31:0];
    end
  endfunction

endpackage

// File: rtl/cmd_streamer_fifo.sv
// cmd_fifo: synchronous FIFO with occupancy count and a synchronous flush.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cmd_streamer.sv
// Command streamer: fetches 32-bit commands from a ring buffer in memory into
// a small FIFO and writes the consumer pointer back when the ring drains.
// Optional build macro CMD_STREAM_PERF_EN adds push and stall perf counters.
module cmd_streamer
  import gpu_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_enable,
  input  logic [31:0]       cmd_ring_base,
  input  logic [31:0]       cmd_ring_size_bytes,
  input  logic [31:0]       cmd_cons_ptr_bytes,
  input  logic [31:0]       cmd_completion_base,
  input  logic              db_valid,
  input  logic [31:0]       db_prod_ptr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [31:0]       cmd_data,
  output logic [31:0]       cons_ptr,
  output logic              busy,
  output logic              cfg_err,
`ifdef CMD_STREAM_PERF_EN
  output logic [31:0]       perf_cmd_count,
  output logic [31:0]       perf_stall_cycles,
`endif
  output cmd_stream_state_t dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // mem_req_* fields stay constant while mem_req_valid && !mem_req_ready;
  // cmd_data is the FIFO head and is popped when cmd_valid && cmd_ready.

  cmd_stream_state_t state_q;
  logic              en_q;
  logic              cfg_err_q;
  logic              drop_q;
  logic [31:0]       prod_q;
  logic [31:0]       cons_q;
  logic [31:0]       last_comp_q;
  logic              req_valid_q;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [31:0]       req_wdata_q;

  logic              en_rise;
  logic              en_fall;
  logic              enabled;
  logic              ring_empty;
  logic              cfg_bad;
  logic              fifo_has_room;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [31:0]       fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       cons_d;
  logic [ADDR_W-1:0] fetch_addr_d;

  assign en_rise    = cmd_enable && !en_q;
  assign en_fall    = !cmd_enable && en_q;
  // The enable-edge cycle only loads pointers; decisions start one cycle later.
  assign enabled    = cmd_enable && en_q;
  assign ring_empty = (cons_q == prod_q);
  assign cfg_bad    = (cmd_ring_size_bytes == 32'd0) ||
                      (cmd_ring_size_bytes[1:0] != 2'b00) ||
                      (cmd_cons_ptr_bytes >= cmd_ring_size_bytes);

  // In IDLE nothing is in flight, so a free slot is the whole room check.
  assign fifo_has_room = (fifo_count < CW'(FIFO_DEPTH));
  assign cons_d        = ring_advance(cons_q, cmd_ring_size_bytes);
  assign fetch_addr_d  = ADDR_W'(cmd_ring_base + cons_q);

  assign fifo_push = (state_q == FETCH_WAIT) && mem_rsp_valid && cmd_enable && !drop_q;
  assign fifo_pop  = !fifo_empty && cmd_ready;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (en_fall),
    .push_i  (fifo_push),
    .wdata_i (mem_rsp_rdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      cfg_err_q   <= 1'b0;
      drop_q      <= 1'b0;
      prod_q      <= '0;
      cons_q      <= '0;
      last_comp_q <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      en_q <= cmd_enable;

      if (en_rise) begin
        cons_q      <= cmd_cons_ptr_bytes;
        prod_q      <= cmd_cons_ptr_bytes;
        last_comp_q <= cmd_cons_ptr_bytes;
        cfg_err_q   <= cfg_bad;
      end else if (db_valid && cmd_enable) begin
        prod_q <= db_prod_ptr & 32'hFFFF_FFFC;
      end

      case (state_q)
        IDLE: begin
          if (enabled && !cfg_err_q && !ring_empty && fifo_has_room) begin
            state_q     <= FETCH_REQ;
            req_valid_q <= 1'b1;
            req_we_q    <= 1'b0;
            req_addr_q  <= fetch_addr_d;
            req_wdata_q <= '0;
          end else if (enabled && !cfg_err_q && ring_empty && (cons_q != last_comp_q)) begin
            state_q     <= COMP_REQ;
            req_valid_q <= 1'b1;
            req_we_q    <= 1'b1;
            req_addr_q  <= ADDR_W'(cmd_completion_base);
            req_wdata_q <= cons_q;
          end
        end
        FETCH_REQ: begin
          if (!cmd_enable) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
          end else if (mem_req_ready) begin
            state_q     <= FETCH_WAIT;
            req_valid_q <= 1'b0;
            drop_q      <= 1'b0;
          end
        end
        FETCH_WAIT: begin
          // The read is still owed by memory, so an abort waits for it and drops it.
          if (!cmd_enable) begin
            drop_q <= 1'b1;
          end
          if (mem_rsp_valid) begin
            if (cmd_enable && !drop_q) begin
              cons_q <= cons_d;
            end
            drop_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        COMP_REQ: begin
          if (!cmd_enable) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
          end else if (mem_req_ready) begin
            last_comp_q <= cons_q;
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gating with enable withdraws a request in the same cycle enable drops.
  assign mem_req_valid = req_valid_q && cmd_enable;
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;

  assign cmd_valid = !fifo_empty;
  assign cmd_data  = fifo_rdata;
  assign cons_ptr  = cons_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;

`ifdef CMD_STREAM_PERF_EN
  logic [31:0] perf_cmd_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cmd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (en_rise) begin
        perf_cmd_q <= '0;
      end else if (fifo_push) begin
        perf_cmd_q <= perf_cmd_q + 32'd1;
      end
      if (cmd_valid && !cmd_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cmd_count    = perf_cmd_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_cmd_streamer.sv
// Bench for cmd_streamer: randomized ring scenarios against a ring-walk model,
// with a memory responder and a scoreboard monitor for requests and commands.
`timescale 1ns/1ps
module tb_cmd_streamer;
  import gpu_cmd_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_enable;
  logic [31:0] cmd_ring_base, cmd_ring_size_bytes, cmd_cons_ptr_bytes, cmd_completion_base;
  logic        db_valid;
  logic [31:0] db_prod_ptr;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_data, cons_ptr;
  logic        busy, cfg_err;
  cmd_stream_state_t dbg_state;
`ifdef CMD_STREAM_PERF_EN
  logic [31:0] perf_cmd_count, perf_stall_cycles;
`endif

  cmd_streamer #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_enable          (cmd_enable),
    .cmd_ring_base       (cmd_ring_base),
    .cmd_ring_size_bytes (cmd_ring_size_bytes),
    .cmd_cons_ptr_bytes  (cmd_cons_ptr_bytes),
    .cmd_completion_base (cmd_completion_base),
    .db_valid            (db_valid),
    .db_prod_ptr         (db_prod_ptr),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_we          (mem_req_we),
    .mem_req_addr        (mem_req_addr),
    .mem_req_wdata       (mem_req_wdata),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_rdata       (mem_rsp_rdata),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_data            (cmd_data),
    .cons_ptr            (cons_ptr),
    .busy                (busy),
    .cfg_err             (cfg_err),
`ifdef CMD_STREAM_PERF_EN
    .perf_cmd_count      (perf_cmd_count),
    .perf_stall_cycles   (perf_stall_cycles),
`endif
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [64:0] exp_req_q[$];   // {we, addr, wdata}
  logic [31:0] exp_cmd_q[$];
  logic [31:0] ring_mem [64];
  logic [31:0] cur_base;

  int reads_acc   = 0;   // written by monitor
  logic [31:0] rd_addr;  // written by monitor
  int rsp_issued  = 0;   // written by responder
  int stall_used  = 0;   // written by responder
  int hold_after  = 32'h7fff_ffff;  // written by stimulus
  int stall_req   = 0;   // written by stimulus
  logic cmd_hold  = 1'b0;

  logic        prev_stall = 1'b0;
  logic [65:0] prev_req;
  logic [64:0] e_req;
  logic [31:0] e_cmd;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder / consumer driver ----------------
  logic rsp_armed = 1'b0;
  int   rsp_delay = 0;
  always @(posedge clk) begin
    #1;
    mem_rsp_valid = 1'b0;
    if (reads_acc > rsp_issued && rsp_issued < hold_after) begin
      if (!rsp_armed) begin
        rsp_armed = 1'b1;
        rsp_delay = $urandom_range(0, 3);
      end
      if (rsp_delay == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = ring_mem[((rd_addr - cur_base) >> 2) & 32'd63];
        rsp_issued++;
        rsp_armed = 1'b0;
      end else begin
        rsp_delay--;
      end
    end
    if (mem_req_valid && stall_used < stall_req) begin
      mem_req_ready = 1'b0;
      stall_used++;
    end else begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
    end
    cmd_ready = cmd_hold ? 1'b0 : ($urandom_range(0, 1) == 1);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && cmd_enable)
        check("req_hold", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata}, prev_req);
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_req   = {1'b1, mem_req_we, mem_req_addr, mem_req_wdata};
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got we=%0d addr=%0h data=%0h, required none",
                   mem_req_we, mem_req_addr, mem_req_wdata);
        end else begin
          e_req = exp_req_q.pop_front();
          if (e_req[64]) check("mem_write", {mem_req_we, mem_req_addr, mem_req_wdata}, e_req);
          else           check("mem_read", {mem_req_we, mem_req_addr}, e_req[64:32]);
        end
        if (!mem_req_we) begin
          check("one_outstanding", reads_acc - rsp_issued, 0);
          rd_addr = mem_req_addr;
          reads_acc++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd: got %0h, required none", cmd_data);
        end else begin
          e_cmd = exp_cmd_q.pop_front();
          check("cmd_data", cmd_data, e_cmd);
        end
      end
    end
  end

  // ---------------- reference model and driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Walks the ring from cons to prod: one read and one command per word,
  // then one completion write if the consumer moved.
  task automatic model_ring(input logic [31:0] base, input logic [31:0] size,
                            input logic [31:0] cons, input logic [31:0] prod,
                            input logic [31:0] comp, output logic [31:0] fin);
    logic [31:0] c = cons;
    int guard = 0;
    while (c != prod && guard < 64) begin
      exp_req_q.push_back({1'b0, base + c, 32'h0});
      exp_cmd_q.push_back(ring_mem[c >> 2]);
      c = (c + 4 >= size) ? 32'h0 : c + 4;
      guard++;
    end
    if (c != cons) exp_req_q.push_back({1'b1, comp, c});
    fin = c;
  endtask

  task automatic setup(input logic [31:0] base, input logic [31:0] size,
                       input logic [31:0] cons, input logic [31:0] comp);
    cmd_enable = 1'b0;
    tick(2);
    cmd_ring_base = base; cmd_ring_size_bytes = size;
    cmd_cons_ptr_bytes = cons; cmd_completion_base = comp;
    cur_base = base;
    for (int i = 0; i < 64; i++) ring_mem[i] = $urandom;
    cmd_enable = 1'b1;
    tick(2);
  endtask

  task automatic doorbell(input logic [31:0] p);
    db_prod_ptr = p; db_valid = 1'b1;
    tick(1);
    db_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int cyc = 0;
    while ((exp_req_q.size() != 0 || exp_cmd_q.size() != 0 || busy) && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    total++;
    if (cyc >= 3000) begin
      bad++;
      $display("FAIL %s_drain: got %0d reqs %0d cmds pending, required 0", nm,
               exp_req_q.size(), exp_cmd_q.size());
    end
    tick(2);
  endtask

  task automatic scenario(input string nm, input logic [31:0] base, input logic [31:0] size,
                          input logic [31:0] cons, input logic [31:0] db,
                          input logic [31:0] comp, input bit hold, input int stall);
    logic [31:0] fin;
    int r0, words;
    setup(base, size, cons, comp);
    check({nm, "_cfg_err"}, cfg_err, 0);
    stall_req = stall_req + stall;
    cmd_hold  = hold;
    r0 = reads_acc;
    model_ring(base, size, cons, db & 32'hFFFF_FFFC, comp, fin);
    words = exp_cmd_q.size();
    doorbell(db);
    if (hold) begin
      tick(80);
      check({nm, "_reads_stalled"}, reads_acc - r0, (words < FIFO_DEPTH) ? words : FIFO_DEPTH);
      cmd_hold = 1'b0;
    end
    wait_drain(nm);
    check({nm, "_cons_ptr"}, cons_ptr, fin);
    check({nm, "_reads_total"}, reads_acc - r0, words);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int r0, cyc;
    logic [31:0] sz, cs, pd;
    rst_n = 1'b0;
    cmd_enable = 1'b0; db_valid = 1'b0; db_prod_ptr = '0;
    cmd_ring_base = '0; cmd_ring_size_bytes = '0; cmd_cons_ptr_bytes = '0; cmd_completion_base = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; cmd_ready = 1'b0;
    cur_base = '0; rd_addr = '0;
    for (int i = 0; i < 64; i++) ring_mem[i] = '0;
    tick(3);
    check("rst_outputs", {mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, cmd_valid},
          {1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    check("rst_cmd_data", cmd_data, 0);
    check("rst_status", {cons_ptr, busy, cfg_err}, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    tick(2);

    scenario("basic", 32'h1000, 32'h20, 32'h0, 32'h0C, 32'h2000, 1'b0, 0);
    scenario("wrap",  32'h4000, 32'h10, 32'h8, 32'h04, 32'h3000, 1'b0, 0);
    scenario("bp",    32'h5000, 32'h40, 32'h0, 32'h20, 32'h5800, 1'b1, 0);
    scenario("stall", 32'h6000, 32'h20, 32'h4, 32'h0B, 32'h6800, 1'b0, 5);
    check("stall_applied", stall_used, stall_req);

    // Disable while a read is outstanding: the late response is dropped.
    setup(32'h8000, 32'h10, 32'h0, 32'h9000);
    cmd_hold = 1'b1;
    hold_after = rsp_issued + 1;
    exp_req_q.push_back({1'b0, 32'h8000, 32'h0});
    exp_req_q.push_back({1'b0, 32'h8004, 32'h0});
    r0 = reads_acc;
    doorbell(32'h08);
    cyc = 0;
    while (reads_acc - r0 < 2 && cyc < 500) begin tick(1); cyc++; end
    check("dis_second_read", reads_acc - r0, 2);
    tick(2);
    check("dis_state_wait", dbg_state, FETCH_WAIT);
    check("dis_fifo_before", cmd_valid, 1);
    check("dis_cons_before", cons_ptr, 32'h04);
    cmd_enable = 1'b0;
    tick(3);
    check("dis_flushed", cmd_valid, 0);
    check("dis_still_wait", dbg_state, FETCH_WAIT);
    hold_after = 32'h7fff_ffff;
    tick(8);
    check("dis_state_idle", dbg_state, IDLE);
    check("dis_cons_after", cons_ptr, 32'h04);
    check("dis_busy", busy, 0);
    check("dis_no_comp", exp_req_q.size(), 0);
    cmd_hold = 1'b0;
    tick(5);

    // Bad configurations: no traffic, sticky error until a valid enable edge.
    setup(32'h7000, 32'h0E, 32'h0, 32'h7800);
    check("cfg_size_err", cfg_err, 1);
    r0 = reads_acc;
    doorbell(32'h04);
    tick(20);
    check("cfg_no_reads", reads_acc - r0, 0);
    check("cfg_idle", {busy, mem_req_valid}, 0);
    cmd_enable = 1'b0;
    tick(2);
    check("cfg_sticky", cfg_err, 1);
    setup(32'h7000, 32'h10, 32'h10, 32'h7800);
    check("cfg_cons_err", cfg_err, 1);
    scenario("cfg_ok", 32'h7000, 32'h10, 32'h0, 32'h0C, 32'h7800, 1'b0, 0);

    for (int k = 0; k < 8; k++) begin
      sz = 4 * $urandom_range(2, 16);
      cs = 4 * $urandom_range(0, sz / 4 - 1);
      pd = (4 * $urandom_range(0, sz / 4 - 1)) | $urandom_range(0, 3);
      scenario("rand", 32'h0001_0000 + 32'h200 * k, sz, cs, pd,
               32'h0002_0000 + 32'h10 * k, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
